controller: RTL and testbench

//   Main control decoder of the single-cycle MIPS CPU. Decodes the 6-bit

---
 rtl/controller.sv | 145 ++++++++++++++
 tb/tb_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//   Main control decoder for the single-cycle MIPS datapath. OpCode (and Funct
//   for R-type) are decoded combinationally, then registered, so the datapath
//   sees the steering signals one clock after the instruction fields arrive.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset, clears every output
//   OpCode   in   6  instruction[31:26]
//   Funct    in   6  instruction[5:0], only looked at for OpCode 6'h00
//   J        out  1  unconditional jump select
//   B        out  1  beq branch enable
//   RegDst   out  1  1: write rd, 0: write rt
//   RegWr    out  1  register file write enable
//   ALUSrc   out  1  1: operand B is sign-extended imm, 0: rt
//   MemWr    out  1  data memory write enable
//   Mem2Reg  out  1  1: writeback from memory, 0: from ALU
//   ALUCtr   out  4  AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111
//   Illegal  out  1  unsupported opcode, or unsupported funct under R-type
// -----------------------------------------------------------------------------
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       J,
  output logic       B,
  output logic       RegDst,
  output logic       RegWr,
  output logic       ALUSrc,
  output logic       MemWr,
  output logic       Mem2Reg,
  output logic [3:0] ALUCtr,
  output logic       Illegal
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic       j;
    logic       b;
    logic       reg_dst;
    logic       reg_wr;
    logic       alu_src;
    logic       mem_wr;
    logic       mem2reg;
    logic [3:0] alu_ctr;
    logic       illegal;
  } ctrl_t;

  ctrl_t      ctrl_d, ctrl_q;
  logic [3:0] r_alu;
  logic       r_ok;

  // R-type funct decode, kept separate so the opcode case stays a flat table.
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (Funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  // Main decode. The default is the illegal encoding: every enable low and
  // ALUCtr=ADD, so an unknown instruction can never write state.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.alu_ctr = ALU_ADD;
    ctrl_d.illegal = 1'b1;
    case (OpCode)
      OP_RTYPE: begin
        // An unsupported funct falls back to the illegal encoding above.
        if (r_ok) begin
          ctrl_d.reg_dst = 1'b1;
          ctrl_d.reg_wr  = 1'b1;
          ctrl_d.alu_ctr = r_alu;
          ctrl_d.illegal = 1'b0;
        end
      end
      OP_LW: begin
        ctrl_d.reg_wr  = 1'b1;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.mem2reg = 1'b1;
        ctrl_d.illegal = 1'b0;
      end
      OP_SW: begin
        ctrl_d.alu_src = 1'b1;
        ctrl_d.mem_wr  = 1'b1;
        ctrl_d.illegal = 1'b0;
      end
      OP_BEQ: begin
        ctrl_d.b       = 1'b1;
        ctrl_d.alu_ctr = ALU_SUB;
        ctrl_d.illegal = 1'b0;
      end
      OP_J: begin
        ctrl_d.j       = 1'b1;
        ctrl_d.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // Reset clears everything, including ALUCtr, and wins over decode.
  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign J       = ctrl_q.j;
  assign B       = ctrl_q.b;
  assign RegDst  = ctrl_q.reg_dst;
  assign RegWr   = ctrl_q.reg_wr;
  assign ALUSrc  = ctrl_q.alu_src;
  assign MemWr   = ctrl_q.mem_wr;
  assign Mem2Reg = ctrl_q.mem2reg;
  assign ALUCtr  = ctrl_q.alu_ctr;
  assign Illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//   Scoreboard bench for controller. Each stimulus cycle pushes the expected
//   output word for the following rising edge; each test pops and compares it
//   after that edge.
//   Word layout: {J,B,RegDst,RegWr,ALUSrc,MemWr,Mem2Reg,ALUCtr[3:0],Illegal}
// -----------------------------------------------------------------------------
module tb_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] Funct  = 6'h20;
  logic       J, B, RegDst, RegWr, ALUSrc, MemWr, Mem2Reg, Illegal;
  logic [3:0] ALUCtr;

  int n_vec  = 0;
  int n_miss = 0;
  logic [11:0] exp_q[$];

  controller dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct),
    .J(J), .B(B), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc(ALUSrc),
    .MemWr(MemWr), .Mem2Reg(Mem2Reg), .ALUCtr(ALUCtr), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // Reference table, written straight from the decode table.
  function automatic logic [11:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic r);
    logic [11:0] e;
    if (r) return 12'b0;
    e = 12'b0000000_0010_1;               // illegal: no enables, ADD, Illegal=1
    case (op)
      6'h00: case (fn)
        6'h20: e = 12'b0011000_0010_0;
        6'h22: e = 12'b0011000_0110_0;
        6'h24: e = 12'b0011000_0000_0;
        6'h25: e = 12'b0011000_0001_0;
        6'h2a: e = 12'b0011000_0111_0;
        default: ;
      endcase
      6'h23: e = 12'b0001101_0010_0;
      6'h2b: e = 12'b0000110_0010_0;
      6'h04: e = 12'b0100000_0110_0;
      6'h02: e = 12'b1000000_0010_0;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [11:0] observed();
    return {J, B, RegDst, RegWr, ALUSrc, MemWr, Mem2Reg, ALUCtr, Illegal};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, and step past the edge.
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic r);
    @(negedge clk);
    OpCode = op; Funct = fn; rst = r;
    exp_q.push_back(model(op, fn, r));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e, g;
    for (int i = 0; i < 3; i++) begin
      apply(6'h00, 6'h20, (i < 2));
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL reset[%0d] got=%b want=%b", i, g, e);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h21};
    logic [11:0] e, g;
    foreach (fns[i]) begin
      apply(6'h00, fns[i], 1'b0);
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL rtype fn=%h got=%b want=%b", fns[i], g, e);
      end
    end
  endtask

  task automatic test_lw();
    logic [11:0] e, g;
    for (int f = 'h20; f <= 'h2a; f++) begin
      apply(6'h23, 6'(f), 1'b0);
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL lw fn=%h got=%b want=%b", f, g, e);
      end
    end
  endtask

  // sw sweep, optionally with a one-cycle reset pulse at step rst_at.
  task automatic test_sw(input int rst_at);
    logic [11:0] e, g;
    for (int f = 'h20; f <= 'h2a; f++) begin
      apply(6'h2b, 6'(f), (f - 'h20) == rst_at);
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL sw fn=%h rst_at=%0d got=%b want=%b", f, rst_at, g, e);
      end
      // One-hot-or-zero enables and no MemWr with RegWr.
      n_vec++;
      if (($countones({J, B, MemWr, RegWr}) > 1) || (MemWr && RegWr)) begin
        n_miss++;
        $display("FAIL sw_exclusive got=%b want=at_most_one", {J, B, MemWr, RegWr});
      end
    end
  endtask

  task automatic test_beq_j();
    logic [5:0] ops [2] = '{6'h04, 6'h02};
    logic [5:0] fns [3] = '{6'h20, 6'h3f, 6'h00};
    logic [11:0] e, g;
    foreach (ops[o]) foreach (fns[f]) begin
      apply(ops[o], fns[f], 1'b0);
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL beq_j op=%h fn=%h got=%b want=%b", ops[o], fns[f], g, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [4] = '{6'h3f, 6'h00, 6'h00, 6'h08};
    logic [5:0] fns [4] = '{6'h20, 6'h00, 6'h3f, 6'h20};
    logic [11:0] e, g;
    foreach (ops[i]) begin
      apply(ops[i], fns[i], 1'b0);
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL illegal op=%h fn=%h got=%b want=%b", ops[i], fns[i], g, e);
      end
    end
  endtask

  // Random mixed stream, including reset pulses, back to back.
  task automatic test_back_to_back();
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f, 6'h01};
    logic [5:0] op, fn;
    logic       r;
    logic [11:0] e, g;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(6)];
      fn = (i % 2) ? 6'($urandom_range(63)) : 6'h20 + 6'($urandom_range(10));
      r  = ($urandom_range(15) == 0);
      apply(op, fn, r);
      e = exp_q.pop_front(); g = observed(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL b2b[%0d] op=%h fn=%h rst=%b got=%b want=%b", i, op, fn, r, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw(-1);
    test_beq_j();
    test_illegal();
    test_sw(4);
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
